// File: rtl/rf_wport_arb_if.sv
// Bundle of the RF write-port arbiter signals: WB write, auxiliary result
// handshake, registered RF write, and decode pending-write query.
interface rf_wport_arb_if;
  // aux handshake: a result transfers on a cycle where aux_valid && aux_ready;
  // aux_valid/aux_waddr/aux_wdata must hold until then, and aux_ready does not
  // depend on aux_valid.
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_raddr;
  logic        chk_hit;
  logic        pending;
  logic        stall_req;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output aux_valid, aux_waddr, aux_wdata,
    output chk_raddr,
    input  aux_ready, rf_we, rf_waddr, rf_wdata, chk_hit, pending, stall_req
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  aux_valid, aux_waddr, aux_wdata,
    input  chk_raddr,
    output aux_ready, rf_we, rf_waddr, rf_wdata, chk_hit, pending, stall_req
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Shares the single register-file write port between WB and a buffered
// auxiliary result source. Optional starvation stall: RF_ARB_STARVE_EN.
module rf_wport_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_wport_arb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rf_wport_arb: DEPTH must be a power of two in 2..8");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("rf_wport_arb: STARVE_LIMIT must be in 1..15");
    end

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       waddr_q [DEPTH];
    logic [4:0]       waddr_d [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [31:0]      wdata_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic full, empty, pipe_eff, aux_acc, aux_live, head_valid;
    logic pop, bypass, enq, chk_hit_c;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign pipe_eff   = bus.pipe_we && (bus.pipe_waddr != 5'd0);
    assign aux_acc    = bus.aux_valid && !full;
    // The younger pipe write to the same register makes this aux result dead.
    assign aux_live   = aux_acc && (bus.aux_waddr != 5'd0) &&
                        !(pipe_eff && (bus.aux_waddr == bus.pipe_waddr));
    assign head_valid = !empty && valid_q[rd_ptr_q];

    always_comb begin
        pop        = 1'b0;
        bypass     = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_eff) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.pipe_waddr;
            rf_wdata_d = bus.pipe_wdata;
            pop        = !empty && !head_valid;
        end else if (head_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = waddr_q[rd_ptr_q];
            rf_wdata_d = wdata_q[rd_ptr_q];
            pop        = 1'b1;
        end else begin
            pop = !empty;
            if (empty && aux_live) begin
                bypass     = 1'b1;
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.aux_waddr;
                rf_wdata_d = bus.aux_wdata;
            end
        end
        enq = aux_live && !bypass;
    end

    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_eff && (waddr_q[i] == bus.pipe_waddr)) valid_d[i] = 1'b0;
        end
        if (pop) valid_d[rd_ptr_q] = 1'b0;
        // The tail slot is always free when enq is set, so no kill can race it.
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            waddr_d[wr_ptr_q] = bus.aux_waddr;
            wdata_d[wr_ptr_q] = bus.aux_wdata;
        end
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(enq);
        count_d  = count_q + CW'(enq) - CW'(pop);
    end

    always_comb begin
        chk_hit_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == bus.chk_raddr)) chk_hit_c = 1'b1;
        end
        if (bus.chk_raddr == 5'd0) chk_hit_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= waddr_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

`ifdef RF_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;
    logic       stall_q, stall_d;

    always_comb begin
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (pipe_eff && head_valid && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
        // Stall holds until the FIFO has been seen empty, then drops.
        stall_d = stall_q;
        if (empty) begin
            stall_d = 1'b0;
        end else if (starve_q == LIMIT) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.stall_req = stall_q;
`else
    assign bus.stall_req = 1'b0;
`endif

    assign bus.aux_ready = !full;
    assign bus.pending   = |valid_q;
    assign bus.chk_hit   = chk_hit_c;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
endmodule
